// File: rtl/hamming_pkg.sv
// hamming_pkg: shared definitions for the Hamming SECDED encoder engine.
//   - state_t: encoder FSM states.
//   - DEF_NUM_MSGS / DEF_IN_BASE / DEF_OUT_BASE / DEF_MEM_DEPTH: default layout.
//   - hamming_encode(): (16,11) extended Hamming encoder.
// Build option: define HAMMING_P0_EN to drive codeword bit 0 with the overall
// parity (SECDED). When it is undefined, bit 0 is always 0 (plain SEC).
package hamming_pkg;

    typedef enum logic [2:0] {
        RD_LO = 3'd0,
        RD_HI = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_NUM_MSGS  = 15;
    localparam int DEF_IN_BASE   = 0;
    localparam int DEF_OUT_BASE  = 30;
    localparam int DEF_MEM_DEPTH = 256;

    // Codeword layout, MSB to LSB:
    // {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}
    function automatic logic [15:0] hamming_encode(logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
`ifdef HAMMING_P0_EN
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
`else
        p0 = 1'b0;
`endif
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: byte-wide single-port data memory.
//   clk   : write clock
//   we    : write enable, byte written on the rising edge
//   addr  : byte address (shared by read and write)
//   wdata : write byte
//   rdata : combinational read of core[addr]
// No reset: contents survive a reset of the engine.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] core [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

    assign rdata = core[addr];

endmodule

// File: rtl/top_level_hamming.sv
// top_level_hamming: self-contained Hamming encoder engine.
// Reads NUM_MSGS 11-bit messages (two bytes each from IN_BASE), encodes each
// into a 16-bit codeword and writes it back (low byte first from OUT_BASE),
// then raises done until the next reset.
//   clk   : clock, all state changes on its rising edge
//   reset : asynchronous active-high reset; release starts a run
//   done  : registered, high once every codeword has been written
// Build option: HAMMING_P0_EN selects SECDED (overall parity in bit 0).
// FSM state is visible as the internal signal 'state' (type state_t).
module top_level_hamming
    import hamming_pkg::*;
#(
    parameter int NUM_MSGS  = DEF_NUM_MSGS,
    parameter int IN_BASE   = DEF_IN_BASE,
    parameter int OUT_BASE  = DEF_OUT_BASE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t        state, state_nx;
    logic [AW-1:0] idx;
    logic [7:0]    lo_q;
    logic [2:0]    hi_q;
    logic          done_q;

    logic [AW-1:0] in_addr, out_addr, addr;
    logic          we;
    logic [7:0]    wdata, rdata;
    logic [15:0]   cw;
    logic          last_msg;
    logic          unused_hi_bits;

    // Message i lives at base + 2i; idx never exceeds NUM_MSGS-1.
    assign in_addr  = AW'(IN_BASE)  + {idx[AW-2:0], 1'b0};
    assign out_addr = AW'(OUT_BASE) + {idx[AW-2:0], 1'b0};
    assign last_msg = (idx == AW'(NUM_MSGS - 1));
    assign cw       = hamming_encode({hi_q, lo_q});

    // Upper five bits of each high input byte carry no data.
    assign unused_hi_bits = ^rdata[7:3];

    data_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) dm1 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        state_nx = state;
        addr     = in_addr;
        we       = 1'b0;
        wdata    = 8'h00;
        case (state)
            RD_LO: begin
                addr     = in_addr;
                state_nx = RD_HI;
            end
            RD_HI: begin
                addr     = in_addr + AW'(1);
                state_nx = WR_LO;
            end
            WR_LO: begin
                addr     = out_addr;
                we       = 1'b1;
                wdata    = cw[7:0];
                state_nx = WR_HI;
            end
            WR_HI: begin
                addr     = out_addr + AW'(1);
                we       = 1'b1;
                wdata    = cw[15:8];
                state_nx = last_msg ? DONE : RD_LO;
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = RD_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RD_LO;
            idx    <= '0;
            lo_q   <= 8'h00;
            hi_q   <= 3'b000;
            done_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == RD_LO) begin
                lo_q <= rdata;
            end
            if (state == RD_HI) begin
                hi_q <= rdata[2:0];
            end
            if (state == WR_HI && !last_msg) begin
                idx <= idx + AW'(1);
            end
            // One cycle behind the state so done follows the last write.
            done_q <= (state == DONE);
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_top_level_hamming.sv
module tb_top_level_hamming;
    import hamming_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic done;

    always #5 clk = ~clk;

    top_level_hamming dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] msgs   [15];
    logic [4:0]  hi_pad [15];
    logic        p0_bit;

    // ---------------- reference model ----------------
    // Classic positional Hamming: data fills non-power-of-two positions 1..15
    // in order, parity at position p covers every position with bit p set,
    // codeword bit j holds position j, bit 0 holds overall parity.
    function automatic logic [15:0] ref_cw(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if ((pos & p) != 0 && pos != p) par = par ^ c[pos];
            end
            c[p] = par;
        end
`ifdef HAMMING_P0_EN
        c[0] = ^c[15:1];
`else
        c[0] = 1'b0;
`endif
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    // Preload inputs (random junk in ignored bits) and fill the output region
    // plus four bytes beyond it with a sentinel.
    task automatic load_msgs();
        for (int i = 0; i < 15; i++) begin
            hi_pad[i] = 5'($urandom);
            dut.dm1.core[2*i]   <= msgs[i][7:0];
            dut.dm1.core[2*i+1] <= {hi_pad[i], msgs[i][10:8]};
        end
        for (int j = 30; j < 64; j++) dut.dm1.core[j] <= 8'hA5;
        #1;
    endtask

    task automatic random_msgs();
        for (int i = 0; i < 15; i++) msgs[i] = 11'($urandom_range(0, 2047));
    endtask

    // Caller has just released reset on a falling edge.
    task automatic run_to_done(output int edges);
        edges = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = c;
                break;
            end
        end
    endtask

    task automatic start_run();
        reset = 1'b1;
        load_msgs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (dut.state !== RD_LO) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, RD_LO); end
        n_cmp++; if (dut.idx !== '0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", dut.idx); end
        n_cmp++; if (dut.lo_q !== 8'h00) begin n_bad++; $display("FAIL reset_lo: got %h want 00", dut.lo_q); end
        n_cmp++; if (dut.hi_q !== 3'b000) begin n_bad++; $display("FAIL reset_hi: got %b want 000", dut.hi_q); end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 15; i++) msgs[i] = '0;
        reset = 1'b1;
        load_msgs();
        for (int i = 0; i < 15; i++) dut.dm1.core[2*i+1] <= 8'h00;
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 59; c++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++; if (dut.dm1.core[59] !== 8'hA5) begin n_bad++; $display("FAIL zero_last_early: got %h want a5 at edge 59", dut.dm1.core[59]); end
        @(posedge clk);
        #1;
        n_cmp++; if (dut.dm1.core[59] !== 8'h00) begin n_bad++; $display("FAIL zero_last_write: got %h want 00 at edge 60", dut.dm1.core[59]); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_60: got %b want 0", done); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done_61: got %b want 1", done); end
        for (int j = 30; j < 60; j++) begin
            n_cmp++;
            if (dut.dm1.core[j] !== 8'h00) begin n_bad++; $display("FAIL zero_out[%0d]: got %h want 00", j, dut.dm1.core[j]); end
        end
    endtask

    task automatic test_directed();
        logic [10:0] dm  [3];
        logic [7:0]  dlo [3];
        logic [7:0]  dhi [3];
        int edges;
        dm[0] = 11'h7FF; dhi[0] = 8'hFF; dlo[0] = 8'hFE | {7'd0, p0_bit};
        dm[1] = 11'h001; dhi[1] = 8'h00; dlo[1] = 8'h0E | {7'd0, p0_bit};
        dm[2] = 11'h400; dhi[2] = 8'h81; dlo[2] = 8'h16 | {7'd0, p0_bit};
        for (int t = 0; t < 3; t++) begin
            random_msgs();
            msgs[0] = dm[t];
            reset = 1'b1;
            load_msgs();
            if (t == 2) begin
                dut.dm1.core[1] <= 8'hFC;
                #1;
            end
            @(negedge clk);
            reset = 1'b0;
            run_to_done(edges);
            n_cmp++; if (edges != 61) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 61", t, edges); end
            n_cmp++; if (dut.dm1.core[30] !== dlo[t]) begin n_bad++; $display("FAIL dir%0d_lo: got %h want %h", t, dut.dm1.core[30], dlo[t]); end
            n_cmp++; if (dut.dm1.core[31] !== dhi[t]) begin n_bad++; $display("FAIL dir%0d_hi: got %h want %h", t, dut.dm1.core[31], dhi[t]); end
        end
    endtask

    task automatic test_random();
        int edges;
        int score;
        logic [15:0] exp_cw, got_cw;
        for (int r = 0; r < 3; r++) begin
            random_msgs();
            start_run();
            run_to_done(edges);
            n_cmp++; if (edges != 61) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want 61", r, edges); end
            score = 0;
            for (int i = 0; i < 15; i++) begin
                exp_cw = ref_cw(msgs[i]);
                got_cw = {dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]};
                n_cmp++;
                if (got_cw !== exp_cw) begin
                    n_bad++;
                    $display("FAIL rnd%0d_cw[%0d]: msg %h got %h want %h", r, i, msgs[i], got_cw, exp_cw);
                end else begin
                    score++;
                end
            end
            $display("round %0d score %0d/15", r, score);
            for (int i = 0; i < 15; i++) begin
                n_cmp++;
                if (dut.dm1.core[2*i] !== msgs[i][7:0] || dut.dm1.core[2*i+1] !== {hi_pad[i], msgs[i][10:8]}) begin
                    n_bad++;
                    $display("FAIL rnd%0d_input[%0d]: got %h%h want %h%h", r, i, dut.dm1.core[2*i+1], dut.dm1.core[2*i], {hi_pad[i], msgs[i][10:8]}, msgs[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int edges;
        logic [15:0] exp_cw, got_cw;
        random_msgs();
        start_run();
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
        n_cmp++; if (dut.state !== RD_LO) begin n_bad++; $display("FAIL mid_state: got %0d want %0d", dut.state, RD_LO); end
        n_cmp++; if (dut.idx !== '0) begin n_bad++; $display("FAIL mid_idx: got %0d want 0", dut.idx); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_to_done(edges);
        n_cmp++; if (edges != 61) begin n_bad++; $display("FAIL mid_latency: got %0d want 61", edges); end
        for (int i = 0; i < 15; i++) begin
            exp_cw = ref_cw(msgs[i]);
            got_cw = {dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]};
            n_cmp++;
            if (got_cw !== exp_cw) begin n_bad++; $display("FAIL mid_cw[%0d]: got %h want %h", i, got_cw, exp_cw); end
        end
    endtask

    // Runs right after test_mid_reset, with done high.
    task automatic test_rerun();
        int edges;
        logic [15:0] exp_cw, got_cw;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL hold_done: got %b want 1", done); end
        for (int j = 60; j < 64; j++) begin
            n_cmp++;
            if (dut.dm1.core[j] !== 8'hA5) begin n_bad++; $display("FAIL stray_write[%0d]: got %h want a5", j, dut.dm1.core[j]); end
        end
        for (int j = 30; j < 60; j++) dut.dm1.core[j] <= 8'hA5;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rerun_done_clear: got %b want 0", done); end
        @(negedge clk);
        reset = 1'b0;
        run_to_done(edges);
        n_cmp++; if (edges != 61) begin n_bad++; $display("FAIL rerun_latency: got %0d want 61", edges); end
        for (int i = 0; i < 15; i++) begin
            exp_cw = ref_cw(msgs[i]);
            got_cw = {dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]};
            n_cmp++;
            if (got_cw !== exp_cw) begin n_bad++; $display("FAIL rerun_cw[%0d]: got %h want %h", i, got_cw, exp_cw); end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
`ifdef HAMMING_P0_EN
        p0_bit = 1'b1;
`else
        p0_bit = 1'b0;
`endif
        test_reset();
        test_all_zero();
        test_directed();
        test_random();
        test_mid_reset();
        test_rerun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_level_hamming.md
# top_level_hamming

Self-contained Hamming SECDED encoder engine that acts as the top-level device in the program-1 test environment. It reads fifteen 11-bit messages from its own data memory, computes a (16,11) extended Hamming codeword for each, and writes the codewords back into the same memory. It then raises `done`. The only external pins are clock, reset and `done`; the bench loads inputs and checks results through hierarchical access to the memory instance.

## Interface
- `NUM_MSGS`, default 15: number of messages processed.
- `IN_BASE`, default 0: byte address of message 0.
- `OUT_BASE`, default 30: byte address of codeword 0.
- `MEM_DEPTH`, default 256: data memory depth in bytes.
- `clk`, input, 1 bit: the single clock. All state changes on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset. Release starts the program.
- `done`, output, 1 bit: high when all codewords are written. Stays high until the next reset.
- Data memory: instance name `dm1`, 8-bit array named `core[0:MEM_DEPTH-1]`. These names are mandatory, because the bench reads and writes the array hierarchically.

## Operation
- Input layout for message i, with data bits d11..d1:
  - `core[IN_BASE+2i]` = d8..d1.
  - `core[IN_BASE+2i+1]` bits [2:0] = d11..d9. Bits [7:3] are ignored.
- Parity equations:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1] ^ p8 ^ p4 ^ p2 ^ p1
- 16-bit codeword, MSB to LSB: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
- The codeword is written to `core[OUT_BASE+2i]` (low byte) and `core[OUT_BASE+2i+1]` (high byte).
- Messages are processed in order i = 0..NUM_MSGS-1.
- Memory reads are combinational. Memory writes are synchronous, one byte per cycle, single port.
- Reset does not clear memory. Contents preloaded before reset must survive it.
- FSM states and transitions:
  - RD_LO: latch the low byte into a data register, then go to RD_HI.
  - RD_HI: latch the high byte, then go to WR_LO.
  - WR_LO: write the low codeword byte, then go to WR_HI.
  - WR_HI: write the high codeword byte. If i = NUM_MSGS-1 go to DONE, otherwise increment i and go to RD_LO.
  - DONE: hold state and raise `done`. No further memory writes.
- On reset, the FSM goes to RD_LO with i = 0.

## Timing
- While reset is high, and after reset: `done` = 0, state = RD_LO, index = 0, data registers = 0.
- Each message takes 4 cycles. The last write lands at the 60th rising edge after reset release.
- `done` is registered and rises at the 61st edge after reset release.
- Reset asserted mid-run aborts the run immediately; `done` drops asynchronously. Bytes already written remain in memory. After release the run restarts from message 0.
- Reset asserted while `done` is high clears `done`. The engine then reruns and overwrites its own outputs with identical values.
- Input and output regions must not overlap (OUT_BASE ≥ IN_BASE + 2·NUM_MSGS). No overlap check is made in hardware.

## Configuration
- `HAMMING_P0_EN` defined: p0 is the overall parity as specified above (SECDED). This is the required build for the program-1 check.
- `HAMMING_P0_EN` undefined: bit 0 of every codeword is written as 0 (plain SEC Hamming). All other bits are unchanged.

## Structure
- Package `hamming_pkg` holds:
  - the FSM state enum;
  - default constants NUM_MSGS / IN_BASE / OUT_BASE;
  - a `function automatic logic [15:0] hamming_encode(logic [11:1] d)`.
- One sub-module, `data_mem`: byte array `core`, combinational read, synchronous write-enable, no reset. It is instantiated as `dm1`.
- `top_level_hamming` contains the FSM, the message index, the data registers, and the address/write-data multiplexing.

## Test plan
- All 30 input bytes = 0x00, pulse reset → `done` rises at cycle 61; `core[30..59]` all 0x00.
- Message 0 = 0x7FF (`core[0]`=0xFF, `core[1]`=0x07) → `core[31]`=0xFF, `core[30]`=0xFF.
- Message 0 = 0x001 → `core[31]`=0x00, `core[30]`=0x0F.
- Message 0 = 0x400, with `core[1]`=0xFC so the upper bits must be ignored → `core[31]`=0x81, `core[30]`=0x17.
- 15 random 11-bit messages → every codeword matches the parity equations; score 15/15.
- Assert reset at cycle 20 of a run → `done` = 0 immediately. After release, `done` rises 61 cycles later and all outputs are correct.
